// File: rtl/pipelined_add_sub_pkg.sv
//------------------------------------------------------------------------------
// Module : pipelined_add_sub_pkg
// Brief  : Shared opcode encodings, saturation limits and configuration checks
//          for the pipelined add/subtract unit.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package pipelined_add_sub_pkg;

    localparam logic OP_ADD    = 1'b0;
    localparam logic OP_SUB    = 1'b1;
    localparam int   MAX_WIDTH = 64;

    // Largest positive two's-complement value of the given width: {0,{w-1{1}}}
    function automatic logic [MAX_WIDTH-1:0] sat_pos_limit(input int width);
        logic [MAX_WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < width - 1; i++) begin
            v[i] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [MAX_WIDTH-1:0] sat_neg_limit(input int width);
        logic [MAX_WIDTH-1:0] v;
        v = '0;
        v[width-1] = 1'b1;
        return v;
    endfunction

    function automatic bit cfg_ok(input int width, input int stages);
        return (width >= 2) && (width <= MAX_WIDTH) && (stages >= 1) &&
               (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pipelined_add_sub_if.sv
//------------------------------------------------------------------------------
// Module : pipelined_add_sub_if
// Brief  : Operand/result valid-ready bundle of the pipelined add/subtract unit.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface pipelined_add_sub_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] Ain;
    logic [WIDTH-1:0] Bin;
    logic             Cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Sout;
    logic             Cout;
    logic             Ovf;

    modport master (
        output in_valid, Ain, Bin, Cin, sub, out_ready,
        input  in_ready, out_valid, Sout, Cout, Ovf
    );

    modport slave (
        input  in_valid, Ain, Bin, Cin, sub, out_ready,
        output in_ready, out_valid, Sout, Cout, Ovf
    );
endinterface

`default_nettype wire

// File: rtl/pipelined_add_sub_slice.sv
//------------------------------------------------------------------------------
// Module : add_sub_slice (with full_adder cell)
// Brief  : W-bit ripple-carry slice; also exposes the carry into its MSB so the
//          top slice can derive signed overflow.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module add_sub_slice #(
    parameter int W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co,
    output logic         c_msb
);
    logic [W:0] w_c;

    assign w_c[0] = ci;

    for (genvar i = 0; i < W; i++) begin : g_bit
        full_adder u_fa (
            .a  (a[i]),
            .b  (b[i]),
            .ci (w_c[i]),
            .s  (s[i]),
            .co (w_c[i+1])
        );
    end

    assign co    = w_c[W];
    assign c_msb = w_c[W-1];
endmodule

`default_nettype wire

// File: rtl/pipelined_add_sub.sv
//------------------------------------------------------------------------------
// Module : pipelined_add_sub
// Brief  : STAGES-deep pipelined add/subtract with valid/ready and global stall.
//          Optional macro PIPELINED_ADD_SUB_SATURATE_EN clamps Sout on overflow.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module pipelined_add_sub
    import pipelined_add_sub_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    pipelined_add_sub_if.slave bus
);
    localparam int SLICE = WIDTH / STAGES;
    localparam int LAST  = STAGES - 1;

    if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_check
        $error("pipelined_add_sub: WIDTH must be >= 2 and divisible by STAGES");
    end

    logic             w_en;
    logic [WIDTH-1:0] w_b_eff;
    logic             w_c0;
    logic             w_ovf;
    logic [WIDTH-1:0] w_s_final;

    logic [WIDTH-1:0] w_a_in     [STAGES];
    logic [WIDTH-1:0] w_b_in     [STAGES];
    logic             w_ci       [STAGES];
    logic             w_v_in     [STAGES];
    logic [SLICE-1:0] w_slice_s  [STAGES];
    logic             w_co       [STAGES];
    logic             w_c_msb    [STAGES];
    logic [WIDTH-1:0] w_s_next   [STAGES];

    logic             r_valid    [STAGES];
    logic [WIDTH-1:0] r_a        [STAGES];
    logic [WIDTH-1:0] r_b        [STAGES];
    logic [WIDTH-1:0] r_s        [STAGES];
    logic             r_c        [STAGES];
    logic             r_ovf;

    // Stall is global: the whole pipe advances only when the output can move.
    assign w_en    = !r_valid[LAST] || bus.out_ready;
    assign w_b_eff = (bus.sub == OP_SUB) ? ~bus.Bin : bus.Bin;
    assign w_c0    = bus.sub ^ bus.Cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            assign w_a_in[k]   = bus.Ain;
            assign w_b_in[k]   = w_b_eff;
            assign w_ci[k]     = w_c0;
            assign w_v_in[k]   = bus.in_valid;
            assign w_s_next[k] = WIDTH'(w_slice_s[k]);
        end else begin : g_next
            assign w_a_in[k]   = r_a[k-1];
            assign w_b_in[k]   = r_b[k-1];
            assign w_ci[k]     = r_c[k-1];
            assign w_v_in[k]   = r_valid[k-1];
            // Earlier stages only ever populate bits below this slice.
            assign w_s_next[k] = r_s[k-1] | (WIDTH'(w_slice_s[k]) << (k * SLICE));
        end

        add_sub_slice #(
            .W (SLICE)
        ) u_slice (
            .a     (w_a_in[k][k*SLICE +: SLICE]),
            .b     (w_b_in[k][k*SLICE +: SLICE]),
            .ci    (w_ci[k]),
            .s     (w_slice_s[k]),
            .co    (w_co[k]),
            .c_msb (w_c_msb[k])
        );
    end

    assign w_ovf = w_co[LAST] ^ w_c_msb[LAST];

`ifdef PIPELINED_ADD_SUB_SATURATE_EN
    localparam logic [WIDTH-1:0] SAT_POS = WIDTH'(sat_pos_limit(WIDTH));
    localparam logic [WIDTH-1:0] SAT_NEG = WIDTH'(sat_neg_limit(WIDTH));

    // Overflow direction follows the sign of A (both operands share it).
    assign w_s_final = !w_ovf                  ? w_s_next[LAST] :
                       w_a_in[LAST][WIDTH-1]   ? SAT_NEG        : SAT_POS;
`else
    assign w_s_final = w_s_next[LAST];
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < STAGES; k++) begin
                r_valid[k] <= 1'b0;
                r_a[k]     <= '0;
                r_b[k]     <= '0;
                r_s[k]     <= '0;
                r_c[k]     <= 1'b0;
            end
            r_ovf <= 1'b0;
        end else if (w_en) begin
            for (int k = 0; k < STAGES; k++) begin
                r_valid[k] <= w_v_in[k];
                r_a[k]     <= w_a_in[k];
                r_b[k]     <= w_b_in[k];
                r_s[k]     <= (k == LAST) ? w_s_final : w_s_next[k];
                r_c[k]     <= w_co[k];
            end
            r_ovf <= w_ovf;
        end
    end

    assign bus.in_ready  = w_en;
    assign bus.out_valid = r_valid[LAST];
    assign bus.Sout      = r_s[LAST];
    assign bus.Cout      = r_c[LAST];
    assign bus.Ovf       = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_pipelined_add_sub.sv
//------------------------------------------------------------------------------
// Module : tb_pipelined_add_sub
// Brief  : Directed-vector bench for pipelined_add_sub (WIDTH=8, STAGES=2) plus
//          random streams on STAGES=1/4/8 copies against a reference model.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_pipelined_add_sub;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] s;
        logic [7:0] s_sat;
        logic       c;
        logic       o;
    } vec_t;

    typedef struct packed {
        logic [7:0] s;
        logic       c;
        logic       o;
    } res_t;

    localparam int NVEC     = 13;
    localparam int SWEEP_N  = 300;

    logic clk;
    logic rst_n;
    logic sweep_rst_n;
    int   n_vec;
    int   n_err;
    int   sweep_done;
    vec_t tbl [NVEC];

    pipelined_add_sub_if #(.WIDTH(8)) bus ();

    pipelined_add_sub #(
        .WIDTH  (8),
        .STAGES (2)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic res_t exp_of(input vec_t v);
        res_t r;
`ifdef PIPELINED_ADD_SUB_SATURATE_EN
        r.s = v.s_sat;
`else
        r.s = v.s;
`endif
        r.c = v.c;
        r.o = v.o;
        return r;
    endfunction

    function automatic res_t model(input logic [7:0] a, input logic [7:0] b,
                                   input logic ci, input logic sb);
        res_t       r;
        logic [7:0] bp;
        logic [8:0] t;
        bp  = sb ? ~b : b;
        t   = {1'b0, a} + {1'b0, bp} + {8'b0, sb ^ ci};
        r.s = t[7:0];
        r.c = t[8];
        r.o = (a[7] == bp[7]) && (t[7] != a[7]);
`ifdef PIPELINED_ADD_SUB_SATURATE_EN
        if (r.o) r.s = a[7] ? 8'h80 : 8'h7F;
`endif
        return r;
    endfunction

    task automatic drive_vec(input vec_t v);
        bus.Ain      = v.a;
        bus.Bin      = v.b;
        bus.Cin      = v.cin;
        bus.sub      = v.sub;
        bus.in_valid = 1'b1;
    endtask

    // One isolated operation: checks exact 2-cycle latency and the result.
    task automatic apply_vec(input vec_t v, input string nm);
        res_t e;
        e = exp_of(v);
        @(negedge clk);
        drive_vec(v);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk({nm, "_early"}, int'(bus.out_valid), 0);
        @(negedge clk);
        chk({nm, "_valid"}, int'(bus.out_valid), 1);
        chk({nm, "_S"},     int'(bus.Sout), int'(e.s));
        chk({nm, "_C"},     int'(bus.Cout), int'(e.c));
        chk({nm, "_V"},     int'(bus.Ovf),  int'(e.o));
    endtask

    // Streams on other depths share the same arithmetic expectations.
    for (genvar gi = 0; gi < 3; gi++) begin : g_sweep
        localparam int ST = (gi == 0) ? 1 : ((gi == 1) ? 4 : 8);

        pipelined_add_sub_if #(.WIDTH(8)) sbus ();

        pipelined_add_sub #(
            .WIDTH  (8),
            .STAGES (ST)
        ) u_dut_s (
            .clk   (clk),
            .rst_n (sweep_rst_n),
            .bus   (sbus)
        );

        initial begin
            res_t q[$];
            res_t e;
            int   sent;
            int   cyc;
            sent           = 0;
            cyc            = 0;
            sbus.in_valid  = 1'b0;
            sbus.out_ready = 1'b0;
            sbus.Ain       = '0;
            sbus.Bin       = '0;
            sbus.Cin       = 1'b0;
            sbus.sub       = 1'b0;
            @(posedge sweep_rst_n);
            while ((sent < SWEEP_N || q.size() != 0) && cyc < 5000) begin
                @(negedge clk);
                cyc++;
                sbus.out_ready = ($urandom_range(0, 3) != 0);
                if (sent < SWEEP_N) begin
                    sbus.Ain      = 8'($urandom_range(0, 255));
                    sbus.Bin      = 8'($urandom_range(0, 255));
                    sbus.Cin      = 1'($urandom_range(0, 1));
                    sbus.sub      = 1'($urandom_range(0, 1));
                    sbus.in_valid = ($urandom_range(0, 4) != 0);
                end else begin
                    sbus.in_valid = 1'b0;
                end
                #1;
                if (sbus.out_valid && sbus.out_ready) begin
                    if (q.size() == 0) begin
                        chk($sformatf("sweep%0d_extra", ST), 1, 0);
                    end else begin
                        e = q.pop_front();
                        chk($sformatf("sweep%0d_S", ST), int'(sbus.Sout), int'(e.s));
                        chk($sformatf("sweep%0d_C", ST), int'(sbus.Cout), int'(e.c));
                        chk($sformatf("sweep%0d_V", ST), int'(sbus.Ovf),  int'(e.o));
                    end
                end
                if (sbus.in_valid && sbus.in_ready) begin
                    q.push_back(model(sbus.Ain, sbus.Bin, sbus.Cin, sbus.sub));
                    sent++;
                end
            end
            sbus.in_valid = 1'b0;
            chk($sformatf("sweep%0d_drained", ST), q.size() + (SWEEP_N - sent), 0);
            sweep_done++;
        end
    end

    initial begin
        res_t       e;
        int         idx;
        int         got;
        int         first;
        int         stalls;
        logic       was_stall;
        logic [7:0] held;

        n_vec      = 0;
        n_err      = 0;
        sweep_done = 0;

        //           a      b      cin   sub   s      s_sat  c     o
        tbl[0]  = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b0};
        tbl[1]  = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 8'h7F, 1'b0, 1'b1};
        tbl[2]  = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 8'h80, 1'b1, 1'b1};
        tbl[3]  = '{8'h05, 8'h07, 1'b1, 1'b1, 8'hFD, 8'hFD, 1'b0, 1'b0};
        tbl[4]  = '{8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 8'h01, 1'b0, 1'b0};
        tbl[5]  = '{8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 8'h46, 1'b0, 1'b0};
        tbl[6]  = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 8'h80, 1'b1, 1'b1};
        tbl[7]  = '{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 8'h00, 1'b1, 1'b0};
        tbl[8]  = '{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 8'h10, 1'b0, 1'b0};
        tbl[9]  = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 8'hFF, 1'b1, 1'b0};
        tbl[10] = '{8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 8'h7F, 1'b0, 1'b1};
        tbl[11] = '{8'h00, 8'h01, 1'b1, 1'b1, 8'hFE, 8'hFE, 1'b0, 1'b0};
        tbl[12] = '{8'h3C, 8'h0F, 1'b0, 1'b1, 8'h2D, 8'h2D, 1'b1, 1'b0};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.Ain       = '0;
        bus.Bin       = '0;
        bus.Cin       = 1'b0;
        bus.sub       = 1'b0;
        rst_n         = 1'b0;
        sweep_rst_n   = 1'b0;

        @(negedge clk);
        chk("rst_out_valid", int'(bus.out_valid), 0);
        chk("rst_S",         int'(bus.Sout), 0);
        chk("rst_in_ready",  int'(bus.in_ready), 1);
        @(negedge clk);
        rst_n       = 1'b1;
        sweep_rst_n = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            apply_vec(tbl[i], $sformatf("vec%0d", i));
        end

        // Six back-to-back ops; consumer refuses for 3 cycles after first result.
        idx       = 0;
        got       = 0;
        first     = -1;
        stalls    = 0;
        was_stall = 1'b0;
        held      = '0;
        for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
            @(negedge clk);
            if (bus.out_valid && first < 0) first = cyc;
            bus.out_ready = !(first >= 0 && cyc < first + 3);
            if (idx < 6) drive_vec(tbl[idx]);
            else         bus.in_valid = 1'b0;
            #1;
            if (bus.out_valid && !bus.out_ready) begin
                stalls++;
                chk("bp_in_ready", int'(bus.in_ready), 0);
                if (was_stall) chk("bp_hold", int'(bus.Sout), int'(held));
                held      = bus.Sout;
                was_stall = 1'b1;
            end else begin
                was_stall = 1'b0;
            end
            if (bus.out_valid && bus.out_ready) begin
                e = exp_of(tbl[got]);
                chk($sformatf("bp%0d_S", got), int'(bus.Sout), int'(e.s));
                chk($sformatf("bp%0d_C", got), int'(bus.Cout), int'(e.c));
                chk($sformatf("bp%0d_V", got), int'(bus.Ovf),  int'(e.o));
                got++;
            end
            if (bus.in_valid && bus.in_ready) idx++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        chk("bp_results", got, 6);
        chk("bp_stalls", stalls, 3);

        // Fill the pipe under backpressure, then reset asynchronously mid-stream.
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.Ain       = 8'h80;
        bus.Bin       = 8'h80;
        bus.Cin       = 1'b1;
        bus.sub       = 1'b0;
        bus.in_valid  = 1'b1;
        repeat (3) @(negedge clk);
        bus.in_valid = 1'b0;
        chk("mid_pre_valid", int'(bus.out_valid), 1);
        chk("mid_pre_S",     int'(bus.Sout), 1);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid",    int'(bus.out_valid), 0);
        chk("mid_rst_S",        int'(bus.Sout), 0);
        chk("mid_rst_C",        int'(bus.Cout), 0);
        chk("mid_rst_V",        int'(bus.Ovf), 0);
        chk("mid_rst_in_ready", int'(bus.in_ready), 1);
        @(negedge clk);
        rst_n         = 1'b1;
        bus.out_ready = 1'b1;
        apply_vec(tbl[3], "post_rst");
        @(negedge clk);
        chk("post_rst_drained", int'(bus.out_valid), 0);

        for (int i = 0; i < 20000 && sweep_done < 3; i++) @(negedge clk);
        chk("sweep_done", sweep_done, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
